pulse_monitor_avg: RTL and testbench

//  Parametrised period-based heart-rate monitor. Measures tick-quantised time between

---
 rtl/pulse_monitor_avg.sv | 167 ++++++++++++++++
 tb/tb_pulse_monitor_avg.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_monitor_avg.sv
// Heart-rate monitor.
// Measures tick-quantised beat periods and keeps a sliding window of the
// last 2**AVG_LOG2 accepted periods. A restoring divider turns the average
// period into BPM. The block also rejects glitches and flags a lost pulse.
module pulse_monitor_avg #(
  parameter int CLK_HZ   = 1000,
  parameter int TICK_DIV = 10,
  parameter int AVG_LOG2 = 2,
  parameter int MIN_PD   = 20,
  parameter int MAX_PD   = 250,
  parameter int BPM_W    = 10
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  output logic [BPM_W-1:0] bpm,
  output logic             bpm_valid,
  output logic             bpm_update,
  output logic             pulse_led,
  output logic             no_pulse,
  output logic             reject
);
  localparam int TPS   = CLK_HZ / TICK_DIV;
  localparam int NUM   = 60 * TPS;
  localparam int NUM_W = $clog2(NUM + 1);
  localparam int PD_W  = $clog2(MAX_PD + 1);
  localparam int SUM_W = PD_W + AVG_LOG2;
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int TD_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int REM_W = ((NUM_W > PD_W) ? NUM_W : PD_W) + 1;
  localparam int CNT_W = $clog2(NUM_W + 1);
  localparam int FIL_W = AVG_LOG2 + 1;
  localparam int QW    = (NUM_W > BPM_W) ? NUM_W : BPM_W;
  localparam int BMAX  = (1 << BPM_W) - 1;

  typedef enum logic {ARM, TRACK} state_t;

  logic [2:0]                  sync;
  logic                        beat;
  logic [TD_W-1:0]             tcnt;
  logic                        tick;
  state_t                      state;
  logic [PD_W-1:0]             pd;
  logic [DEPTH-1:0][PD_W-1:0]  hist;   // hist[0] newest, hist[DEPTH-1] oldest
  logic [SUM_W-1:0]            sum;
  logic [FIL_W-1:0]            fill;
  logic                        accept, timeout, full_next;
  logic                        req, busy;
  logic [CNT_W-1:0]            cnt;
  logic [REM_W-1:0]            rem, shifted, rem_nxt;
  logic [NUM_W-1:0]            quo, quo_nxt;
  logic [PD_W-1:0]             dvsr;
  logic                        ge;
  logic [QW-1:0]               qx;
  logic [BPM_W-1:0]            q_sat;

  assign pulse_led = beat;
  assign tick      = (tcnt == TD_W'(TICK_DIV - 1));
  assign accept    = (state == TRACK) && beat && (pd >= PD_W'(MIN_PD));
  assign timeout   = (state == TRACK) && !beat && (pd == PD_W'(MAX_PD));
  assign full_next = (fill >= FIL_W'(DEPTH - 1));

  // Restoring divide step: bring down the next dividend bit, subtract if it fits.
  assign shifted = (rem << 1) | {{(REM_W-1){1'b0}}, quo[NUM_W-1]};
  assign ge      = (shifted >= REM_W'(dvsr));
  assign rem_nxt = ge ? shifted - REM_W'(dvsr) : shifted;
  assign quo_nxt = {quo[NUM_W-2:0], ge};
  assign qx      = QW'(quo_nxt);
  assign q_sat   = (qx > QW'(BMAX)) ? {BPM_W{1'b1}} : qx[BPM_W-1:0];

  // Synchronise the raw pulse and emit a one-cycle strobe on its rising edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      beat <= 1'b0;
    end else begin
      sync <= {sync[1:0], pulse_in};
      beat <= sync[1] & ~sync[2];
    end
  end

  // Free-running tick prescaler
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + 1'b1;
  end

  // Beat FSM: period counting, glitch rejection, window update and timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARM;
      pd       <= '0;
      hist     <= '0;
      sum      <= '0;
      fill     <= '0;
      no_pulse <= 1'b0;
      reject   <= 1'b0;
    end else begin
      reject <= 1'b0;
      if (beat && state == ARM) begin
        pd    <= '0;
        state <= TRACK;
      end else if (accept) begin
        hist     <= {hist[DEPTH-2:0], pd};
        sum      <= sum + SUM_W'(pd) - SUM_W'(hist[DEPTH-1]);
        fill     <= full_next ? FIL_W'(DEPTH) : fill + 1'b1;
        pd       <= '0;
        no_pulse <= 1'b0;
      end else begin
        // a short beat in TRACK lands here and leaves the period running
        if (beat) reject <= 1'b1;
        if (tick && pd != PD_W'(MAX_PD)) pd <= pd + 1'b1;
        if (timeout) begin
          no_pulse <= 1'b1;
          hist     <= '0;
          sum      <= '0;
          fill     <= '0;
          state    <= ARM;
        end
      end
    end
  end

  // Divider sequencing: a single request flag doubles as the pending marker
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req        <= 1'b0;
      busy       <= 1'b0;
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      dvsr       <= '0;
      bpm        <= '0;
      bpm_valid  <= 1'b0;
      bpm_update <= 1'b0;
    end else begin
      bpm_update <= 1'b0;
      if (timeout) begin
        req       <= 1'b0;
        busy      <= 1'b0;
        bpm_valid <= 1'b0;
      end else begin
        if (busy) begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            busy       <= 1'b0;
            bpm        <= q_sat;
            bpm_valid  <= 1'b1;
            bpm_update <= 1'b1;
          end
        end else if (req) begin
          req  <= 1'b0;
          busy <= 1'b1;
          cnt  <= CNT_W'(NUM_W);
          rem  <= '0;
          quo  <= NUM_W'(NUM);
          dvsr <= sum[SUM_W-1:AVG_LOG2];
        end
        // a new full-window accept always re-arms the request (newest sum wins)
        if (accept && full_next) req <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pulse_monitor_avg.sv
// Bench for pulse_monitor_avg: directed and random beat trains against a
// timestamp-based reference model of the beat/period/average rules.
module tb_pulse_monitor_avg;
  localparam int MAXPD = 250;
  localparam int MINPD = 20;
  localparam int BPMAX = 1023;
  localparam int NUMV  = 6000;
  localparam int LAT   = 14;  // accept edge -> bpm_update edge

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pulse_in = 1'b0;
  logic [9:0] bpm;
  logic       bpm_valid, bpm_update, pulse_led, no_pulse, reject;

  pulse_monitor_avg dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .bpm(bpm),
    .bpm_valid(bpm_valid), .bpm_update(bpm_update), .pulse_led(pulse_led),
    .no_pulse(no_pulse), .reject(reject)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  int obs_cyc[$], obs_val[$];
  int led_cnt = 0, rej_cnt = 0;
  // reference model state
  int m_hist[$];
  bit m_arm = 1'b1;
  int m_p = 0;
  int exp_cyc[$], exp_val[$];
  int exp_led = 0, exp_rej = 0, exp_bpm = 0;
  bit exp_valid = 1'b0, exp_nop = 1'b0;

  initial begin
    #3ms;
    $display("FAIL watchdog: observed no finish, required finish within 3ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    if (pulse_led === 1'b1) led_cnt++;
    if (reject === 1'b1) rej_cnt++;
    if (bpm_update === 1'b1) begin
      obs_cyc.push_back(cyc);
      obs_val.push_back(int'(bpm));
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) step();
  endtask

  // Apply a timeout if the period since the last reset point ran out by edge 'upto'.
  // Ticks fall on edges that are multiples of 10; the 250th one after m_p saturates.
  task automatic settle(input int upto);
    int t;
    if (!m_arm) begin
      t = 10 * (m_p / 10 + MAXPD);
      if (upto >= t + 1) begin
        m_hist.delete();
        m_arm     = 1'b1;
        exp_valid = 1'b0;
        exp_nop   = 1'b1;
      end
    end
  endtask

  // Beat whose strobe is acted on at edge a.
  task automatic model_beat(input int a);
    int pd, s, q;
    exp_led++;
    settle(a - 1);
    if (m_arm) begin
      m_arm = 1'b0;
      m_p   = a;
    end else begin
      pd = (a - 1) / 10 - m_p / 10;
      if (pd > MAXPD) pd = MAXPD;
      if (pd < MINPD) exp_rej++;
      else begin
        m_hist.push_back(pd);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        m_p     = a;
        exp_nop = 1'b0;
        if (m_hist.size() == 4) begin
          s = 0;
          foreach (m_hist[i]) s += m_hist[i];
          q = NUMV / (s / 4);
          if (q > BPMAX) q = BPMAX;
          exp_cyc.push_back(a + LAT);
          exp_val.push_back(q);
          exp_bpm   = q;
          exp_valid = 1'b1;
        end
      end
    end
  endtask

  // Raise pulse_in now (seen at edge cyc+1, acted on at cyc+4), then wait gap cycles.
  task automatic beat(input int gap);
    pulse_in = 1'b1;
    model_beat(cyc + 4);
    wait_cyc(5);
    pulse_in = 1'b0;
    wait_cyc(gap - 5);
  endtask

  task automatic align();
    while (cyc % 10 != 0) step();
  endtask

  task automatic check_phase(input string tag);
    settle(cyc);
    chk({tag, "_nupd"}, obs_cyc.size(), exp_cyc.size());
    while (obs_cyc.size() > 0 && exp_cyc.size() > 0) begin
      chk({tag, "_upd_cyc"}, obs_cyc.pop_front(), exp_cyc.pop_front());
      chk({tag, "_upd_bpm"}, obs_val.pop_front(), exp_val.pop_front());
    end
    obs_cyc.delete(); obs_val.delete(); exp_cyc.delete(); exp_val.delete();
    chk({tag, "_leds"}, led_cnt, exp_led);
    chk({tag, "_rejects"}, rej_cnt, exp_rej);
    chk({tag, "_valid"}, bpm_valid, exp_valid);
    chk({tag, "_nopulse"}, no_pulse, exp_nop);
    chk({tag, "_bpm"}, bpm, exp_bpm);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_bpm"}, bpm, 0);
    chk({tag, "_valid"}, bpm_valid, 0);
    chk({tag, "_update"}, bpm_update, 0);
    chk({tag, "_led"}, pulse_led, 0);
    chk({tag, "_nopulse"}, no_pulse, 0);
    chk({tag, "_reject"}, reject, 0);
  endtask

  task automatic model_reset();
    m_hist.delete(); m_arm = 1'b1; m_p = 0;
    obs_cyc.delete(); obs_val.delete(); exp_cyc.delete(); exp_val.delete();
    led_cnt = 0; rej_cnt = 0; exp_led = 0; exp_rej = 0; exp_bpm = 0;
    exp_valid = 1'b0; exp_nop = 1'b0;
  endtask

  initial begin
    // reset state
    wait_cyc(3);
    check_zero("reset");
    rst = 1'b1; cyc = 0; model_reset();

    // steady 1000-cycle beats: 5 beats give the first result, 6th repeats it
    align();
    repeat (5) beat(1000);
    check_phase("steady5");
    chk("steady5_lit_bpm", bpm, 60);
    beat(50);
    check_phase("steady6");
    chk("steady6_lit_bpm", bpm, 60);

    // glitch 50 cycles after a beat, then the real beat 1000 after it
    beat(950);
    check_phase("glitch");
    chk("glitch_lit_rej", rej_cnt, 1);
    beat(1000);
    check_phase("after_glitch");
    chk("after_glitch_lit_bpm", bpm, 60);

    // window 100,100,100,50 ticks -> avg 87 -> 68
    beat(1000);
    beat(500);
    beat(100);
    check_phase("avg87");
    chk("avg87_lit_bpm", bpm, 68);

    // lose the pulse, then re-arm and refill the window
    wait_cyc(2500);
    check_phase("timeout");
    chk("timeout_lit_nop", no_pulse, 1);
    chk("timeout_lit_valid", bpm_valid, 0);
    chk("timeout_lit_bpm", bpm, 68);
    beat(1000);
    chk("rearm_lit_nop", no_pulse, 1);
    repeat (3) beat(1000);
    check_phase("refill3");
    chk("refill3_lit_valid", bpm_valid, 0);
    beat(1000);
    check_phase("refill4");
    chk("refill4_lit_bpm", bpm, 60);

    // random gaps, including glitches and accumulated timeouts
    for (int i = 0; i < 20; i++) beat(int'($urandom_range(150, 2400)));
    wait_cyc(30);
    check_phase("random");

    // fast 300-cycle beats
    align();
    repeat (6) beat(300);
    check_phase("fast");
    chk("fast_lit_bpm", bpm, 200);

    // reset in the middle of a divide
    beat(10);
    rst = 1'b0;
    #1;
    check_zero("midrst_async");
    wait_cyc(2);
    check_zero("midrst_edge");
    rst = 1'b1; cyc = 0; model_reset();
    wait_cyc(40);
    check_phase("post_rst");
    align();
    repeat (4) beat(300);
    check_phase("post_rst4");
    chk("post_rst4_lit_valid", bpm_valid, 0);
    beat(300);
    check_phase("post_rst5");
    chk("post_rst5_lit_bpm", bpm, 200);
    chk("post_rst5_lit_valid", bpm_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
